multi_operand_add_ctrl: RTL and testbench

MULTI_OPERAND_ADD_CTRL -- requirements
Module: multi_operand_add_ctrl

---
 rtl/mo_add_pkg.sv | 16 +
 rtl/carry_look_ahead_20_bit.sv | 50 +++++
 rtl/csa.sv | 20 ++
 rtl/multi_operand_add_ctrl.sv | 145 ++++++++++++++
 tb/tb_multi_operand_add_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mo_add_pkg.sv
// Shared defaults and FSM encoding for the multi-operand accumulate/resolve adder.
package mo_add_pkg;

    localparam int unsigned N_OPS_DEF = 9;
    localparam int unsigned W_IN_DEF  = 16;
    localparam int unsigned W_OUT_DEF = 20;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/carry_look_ahead_20_bit.sv
// 20-bit adder: 4-bit lookahead groups with a lookahead carry chain across the five groups.
module carry_look_ahead_20_bit (
    input  logic [19:0] a_i,
    input  logic [19:0] b_i,
    input  logic        cin_i,
    output logic [19:0] sum_o,
    output logic        cout_o
);

    localparam int unsigned W    = 20;
    localparam int unsigned BLK  = 4;
    localparam int unsigned NBLK = 5;

    logic [W-1:0]    g;
    logic [W-1:0]    p;
    logic [W:0]      c;
    logic [NBLK:0]   cb;
    logic [NBLK-1:0] gg;
    logic [NBLK-1:0] gp;

    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        gg = '0;
        gp = '1;
        cb = '0;
        c  = '0;
        // Group generate/propagate
        for (int k = 0; k < int'(NBLK); k++) begin
            for (int j = 0; j < int'(BLK); j++) begin
                gg[k] = g[k*BLK+j] | (p[k*BLK+j] & gg[k]);
                gp[k] = gp[k] & p[k*BLK+j];
            end
        end
        cb[0] = cin_i;
        for (int k = 0; k < int'(NBLK); k++) begin
            cb[k+1] = gg[k] | (gp[k] & cb[k]);
        end
        for (int k = 0; k < int'(NBLK); k++) begin
            c[k*BLK] = cb[k];
            for (int j = 1; j < int'(BLK); j++) begin
                c[k*BLK+j] = g[k*BLK+j-1] | (p[k*BLK+j-1] & c[k*BLK+j-1]);
            end
        end
        c[W]   = cb[NBLK];
        sum_o  = p ^ c[W-1:0];
        cout_o = c[W];
    end

endmodule

// File: rtl/csa.sv
// 3:2 carry-save compressor; carry_o is already shifted left one place and truncated to W.
module csa #(
    parameter int unsigned W = 20
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    always_comb begin
        sum_o   = a_i ^ b_i ^ c_i;
        carry_o = '0;
        for (int i = 1; i < int'(W); i++) begin
            carry_o[i] = (a_i[i-1] & b_i[i-1]) | (a_i[i-1] & c_i[i-1]) | (b_i[i-1] & c_i[i-1]);
        end
    end

endmodule

// File: rtl/multi_operand_add_ctrl.sv
// Sums N_OPS streamed operands in carry-save form, then resolves with a single CLA pass.
module multi_operand_add_ctrl
    import mo_add_pkg::*;
#(
    parameter int unsigned N_OPS = N_OPS_DEF,
    parameter int unsigned W_IN  = W_IN_DEF,
    parameter int unsigned W_OUT = W_OUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             op_valid,
    input  logic [W_IN-1:0]  op_data,
    output logic             op_ready,
    output logic             res_valid,
    output logic [W_OUT-1:0] res_data,
    output logic             res_cout,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_e             state_q,     state_d;
    logic [W_OUT-1:0]   sum_q,       sum_d;
    logic [W_OUT-1:0]   carry_q,     carry_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [W_OUT-1:0]   res_data_q,  res_data_d;
    logic               res_cout_q,  res_cout_d;
    logic               res_valid_q, res_valid_d;
    logic               op_ready_q,  op_ready_d;
    logic               busy_q,      busy_d;

    logic [W_OUT-1:0]   x_ext;
    logic [W_OUT-1:0]   csa_sum;
    logic [W_OUT-1:0]   csa_carry;
    logic [W_OUT-1:0]   cla_sum;
    logic               cla_cout;

    assign x_ext = W_OUT'(op_data);

    csa #(
        .W (W_OUT)
    ) u_csa (
        .a_i     (sum_q),
        .b_i     (carry_q),
        .c_i     (x_ext),
        .sum_o   (csa_sum),
        .carry_o (csa_carry)
    );

    carry_look_ahead_20_bit u_cla (
        .a_i    (sum_q),
        .b_i    (carry_q),
        .cin_i  (1'b0),
        .sum_o  (cla_sum),
        .cout_o (cla_cout)
    );

    // Next-state and registered-output logic; abort wins over operand acceptance
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_cout_d = res_cout_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (op_valid) begin
                    sum_d   = csa_sum;
                    carry_d = csa_carry;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_OPS - 1)) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    res_data_d = cla_sum;
                    res_cout_d = cla_cout;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        op_ready_d  = (state_d == ACCUM);
        res_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_cout_q  <= 1'b0;
            res_valid_q <= 1'b0;
            op_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_cout_q  <= res_cout_d;
            res_valid_q <= res_valid_d;
            op_ready_q  <= op_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign op_ready  = op_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_cout  = res_cout_q;
    assign busy      = busy_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_multi_operand_add_ctrl.sv
// Directed bench: default 9-operand instance plus a 2-operand instance, hand-computed sums.
module tb_multi_operand_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, op_valid, res_ready;
    logic [15:0] op_data;
    logic        op_ready, res_valid, res_cout, busy;
    logic [19:0] res_data;
    logic [3:0]  op_count;

    logic        s2_start, s2_valid;
    logic [15:0] s2_data;
    logic        s2_ready, s2_res_valid, s2_res_cout, s2_busy;
    logic [19:0] s2_res_data;
    logic [3:0]  s2_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_operand_add_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .op_valid  (op_valid),
        .op_data   (op_data),
        .op_ready  (op_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_cout  (res_cout),
        .res_ready (res_ready),
        .busy      (busy),
        .op_count  (op_count)
    );

    multi_operand_add_ctrl #(.N_OPS(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s2_start),
        .abort     (1'b0),
        .op_valid  (s2_valid),
        .op_data   (s2_data),
        .op_ready  (s2_ready),
        .res_valid (s2_res_valid),
        .res_data  (s2_res_data),
        .res_cout  (s2_res_cout),
        .res_ready (1'b1),
        .busy      (s2_busy),
        .op_count  (s2_count)
    );

    // Tasks start and end just after a falling edge; inputs change only there.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_op(input logic [15:0] d, input int gap);
        repeat (gap) begin
            op_valid = 1'b0;
            @(negedge clk);
        end
        op_valid = 1'b1;
        op_data  = d;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({op_ready, res_valid, res_data, res_cout, busy, op_count} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b val=%b data=%h cout=%b busy=%b cnt=%0d, need all 0",
                     op_ready, res_valid, res_data, res_cout, busy, op_count);
        end
        n_checks++;
        if ({s2_ready, s2_res_valid, s2_res_data, s2_res_cout, s2_busy, s2_count} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_n2: got data=%h busy=%b, need all 0", s2_res_data, s2_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        res_ready = 1'b1;
        pulse_start();
        n_checks++;
        if (op_ready !== 1'b1 || busy !== 1'b1 || op_count !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_accum_entry: got rdy=%b busy=%b cnt=%0d, need 1 1 0", op_ready, busy, op_count);
        end
        for (int i = 1; i <= 9; i++) send_op(16'(i), 0);
        n_checks++;
        if (res_valid !== 1'b0 || op_count !== 4'd9 || op_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after_last: got val=%b cnt=%0d rdy=%b, need 0 9 0", res_valid, op_count, op_ready);
        end
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 20'd45 || res_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got val=%b data=%0d cout=%b, need 1 45 0", res_valid, res_data, res_cout);
        end
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release: got val=%b busy=%b, need 0 0", res_valid, busy);
        end
    endtask

    task automatic test_gaps_and_hold();
        int gaps [9] = '{0, 2, 1, 3, 0, 1, 4, 0, 2};
        res_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 9; i++) send_op(16'hFFFF, gaps[i]);
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 20'h8FFF7 || res_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_result: got val=%b data=%h cout=%b, need 1 8fff7 0", res_valid, res_data, res_cout);
        end
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            abort = (c == 6);
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== 20'h8FFF7 || op_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got val=%b data=%h rdy=%b busy=%b, need 1 8fff7 0 1",
                         c, res_valid, res_data, op_ready, busy);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: got val=%b busy=%b rdy=%b, need 0 0 0", res_valid, busy, op_ready);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        for (int i = 0; i < 4; i++) send_op(16'h0001, 0);
        n_checks++;
        if (op_count !== 4'd4 || op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_before_reset: got cnt=%0d rdy=%b, need 4 1", op_count, op_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({op_ready, res_valid, res_data, res_cout, busy, op_count} !== 28'h0) begin
            n_fail++;
            $display("FAIL mid_async_reset: got rdy=%b busy=%b cnt=%0d data=%h, need all 0",
                     op_ready, busy, op_count, res_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || op_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_autostart: got busy=%b rdy=%b, need 0 0", busy, op_ready);
        end
        pulse_start();
        for (int i = 0; i < 9; i++) send_op(16'h0001, 0);
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 20'd9) begin
            n_fail++;
            $display("FAIL mid_new_txn: got val=%b data=%0d, need 1 9", res_valid, res_data);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int seen_valid = 0;
        pulse_start();
        for (int i = 0; i < 5; i++) send_op(16'h0007, 0);
        op_valid = 1'b1;
        op_data  = 16'h0005;
        abort    = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        abort    = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || op_count !== 4'd0 || op_ready !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b cnt=%0d rdy=%b val=%b, need 0 0 0 0",
                     busy, op_count, op_ready, res_valid);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (res_valid) seen_valid++;
        end
        n_checks++;
        if (seen_valid != 0) begin
            n_fail++;
            $display("FAIL abort_no_result: got %0d valid cycles, need 0", seen_valid);
        end
        pulse_start();
        for (int i = 0; i < 9; i++) send_op(16'h0002, 0);
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 20'd18) begin
            n_fail++;
            $display("FAIL abort_next_txn: got val=%b data=%0d, need 1 18", res_valid, res_data);
        end
        @(negedge clk);
    endtask

    task automatic test_nops2();
        s2_start = 1'b1;
        @(negedge clk);
        s2_start = 1'b0;
        s2_valid = 1'b1;
        s2_data  = 16'hFFFF;
        @(negedge clk);
        s2_data  = 16'h0001;
        @(negedge clk);
        s2_valid = 1'b0;
        n_checks++;
        if (s2_res_valid !== 1'b0 || s2_count !== 4'd2) begin
            n_fail++;
            $display("FAIL n2_after_last: got val=%b cnt=%0d, need 0 2", s2_res_valid, s2_count);
        end
        @(negedge clk);
        n_checks++;
        if (s2_res_valid !== 1'b1 || s2_res_data !== 20'h10000 || s2_res_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL n2_result: got val=%b data=%h cout=%b, need 1 10000 0",
                     s2_res_valid, s2_res_data, s2_res_cout);
        end
        @(negedge clk);
    endtask

    initial begin
        start     = 1'b0;
        abort     = 1'b0;
        op_valid  = 1'b0;
        op_data   = '0;
        res_ready = 1'b1;
        s2_start  = 1'b0;
        s2_valid  = 1'b0;
        s2_data   = '0;
        test_reset();
        test_basic();
        test_gaps_and_hold();
        test_reset_mid();
        test_abort();
        test_nops2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
